cp0: RTL and testbench
======================

CP0 -- requirements
Module: cp0

Interface
REQ-001 Parameter PRID_VALUE, default 32'h2025_0007, value returned on reads of register 15 (PRId).
REQ-002 Parameter TRAP_ADDR, default 32'h0000_4180, handler entry address exported on trap.
REQ-003 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 en  input  1  mtc0 write enable, from M stage.
REQ-006 cp0_addr  input  5  register number (rd field) for mfc0/mtc0.
REQ-007 cp0_in  input  32  mtc0 write data.
REQ-008 vpc  input  32  PC of the victim instruction in M stage.
REQ-009 bd_in  input  1  victim is in a branch delay slot.
REQ-010 exc_code_in  input  5  pipelined exception code of the victim; 0 means none.
REQ-011 hw_int  input  6  external interrupt lines (timer0, timer1, interrupt generator, three spare).
REQ-012 exl_clr  input  1  eret in M stage.
REQ-013 cp0_out  output  32  mfc0 read data, combinational.
REQ-014 epc_out  output  32  current EPC, used as the eret target.
REQ-015 int_req  output  1  trap request, combinational; flushes every pipeline register and redirects fetch.
REQ-016 trap_pc  output  32  constant TRAP_ADDR, used as the fetch target while int_req=1.

Function
REQ-017 Registers:
- SR(12): IM[15:10], EXL[1], IE[0]; all other SR bits read 0.
- Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other Cause bits read 0.
- EPC(14): 32 bits.
- PRId(15): constant PRID_VALUE.
REQ-018 int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
REQ-019 exc_pend = (exc_code_in != 0) & ~SR.EXL.
REQ-020 int_req = int_pend | exc_pend.
REQ-021 Priority: an interrupt wins over a synchronous exception in the same cycle.
REQ-022 On a clk edge with int_req=1:
- SR.EXL <= 1.
- Cause.BD <= bd_in.
- Cause.ExcCode <= int_pend ? 0 : exc_code_in.
- EPC <= bd_in ? {vpc[31:2],2'b00} - 4 : {vpc[31:2],2'b00}.
REQ-023 Cause.IP <= hw_int on every non-reset edge, independent of EXL, IM and int_req.
REQ-024 On an edge with int_req=0 and en=1, mtc0 writes: 12 updates IM/EXL/IE only; 14 updates EPC with cp0_in; 13, 15 and all other numbers are ignored.
REQ-025 When int_req=1, mtc0 is suppressed in that cycle; the trap update has priority.
REQ-026 On an edge with int_req=0 and exl_clr=1, SR.EXL <= 0.
REQ-027 If exl_clr=1 and en=1 targets SR in the same cycle, EXL <= 0 and IM/IE take cp0_in.
REQ-028 cp0_out returns the addressed register with unimplemented bits as 0; unimplemented numbers return 0.
REQ-029 mfc0 reads the pre-edge value; there is no internal bypass, because the hazard unit accounts for Tnew=2.
REQ-030 epc_out reflects EPC combinationally, including values written by mtc0 one cycle earlier.
REQ-031 A nested trap while EXL=1 is masked: there is no EPC or Cause update, and an exception code is ignored.
REQ-032 EPC arithmetic wraps modulo 2^32: vpc=0 with bd_in=1 gives EPC 32'hFFFF_FFFC.

Reset
REQ-033 On reset: SR=0, Cause=0, EPC=0, so int_req=0 in the following cycle.
REQ-034 Reset has priority over int_req, en and exl_clr.
REQ-035 int_req may still be asserted combinationally during the reset cycle; downstream reset logic has priority.

Structure
REQ-036 The shared constants file holds:
- Register numbers SR=12, CAUSE=13, EPC=14, PRID=15.
- ExcCode values Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
- TRAPPED_ADDRESS=32'h4180.
REQ-037 Single flat module with no sub-module; the pending logic and the register file are separate always blocks.

Verification
REQ-038 Reset, then mtc0 SR=32'h0000_FC01, then hw_int=6'b000001 -> int_req=1 the same cycle; next cycle Cause.ExcCode=0, Cause.IP[10]=1, EXL=1, EPC=vpc.
REQ-039 exc_code_in=12 (Ov), vpc=32'h3010, bd_in=1, EXL=0 -> int_req=1; EPC=32'h300C, Cause=32'h8000_0030, SR.EXL=1.
REQ-040 EXL=1 and exc_code_in=10 -> int_req=0, EPC unchanged; then exl_clr=1 -> EXL=0 on the next edge.
REQ-041 Same cycle: hw_int[2]=1 unmasked, exc_code_in=4, en=1 writing EPC=32'h5000 -> ExcCode=0, EPC=vpc, mtc0 dropped.
REQ-042 mtc0 Cause=32'hFFFF_FFFF, then mfc0 13 with hw_int=0 -> reads 0.
REQ-043 mfc0 15 -> PRID_VALUE.
REQ-044 IE=0, IM=all ones, hw_int=6'b111111 -> int_req=0 and IP=6'b111111.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes and the trap vector.
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   typedef enum logic [4:0] {
      EXC_INT     = 5'd0,
      EXC_ADEL    = 5'd4,
      EXC_ADES    = 5'd5,
      EXC_SYSCALL = 5'd8,
      EXC_RI      = 5'd10,
      EXC_OV      = 5'd12
   } exc_code_e;

   localparam logic [31:0] TRAPPED_ADDRESS = 32'h0000_4180;

endpackage

// File: rtl/cp0_if.sv
// Pipeline-side signal bundle for CP0: mfc0/mtc0 access, victim info and trap outputs.
interface cp0_if;
   logic        en;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_in;
   logic [31:0] vpc;
   logic        bd_in;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        exl_clr;
   logic [31:0] cp0_out;
   logic [31:0] epc_out;
   logic        int_req;
   logic [31:0] trap_pc;

   modport master (
      output en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
      input  cp0_out, epc_out, int_req, trap_pc
   );

   modport slave (
      input  en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
      output cp0_out, epc_out, int_req, trap_pc
   );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception trap request generation.
module cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h2025_0007,
   parameter logic [31:0] TRAP_ADDR  = 32'h0000_4180
) (
   input  logic   clk,
   input  logic   reset,
   cp0_if.slave   bus
);

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exc_code;
   logic [31:0] r_epc;

   logic        w_int_pend;
   logic        w_exc_pend;
   logic        w_int_req;
   logic [31:0] w_vpc_al;
   logic [31:0] w_epc_trap;

   always_comb begin
      w_int_pend = (|(bus.hw_int & r_im)) & r_ie & ~r_exl;
      w_exc_pend = (bus.exc_code_in != 5'd0) & ~r_exl;
      w_int_req  = w_int_pend | w_exc_pend;
      w_vpc_al   = bus.vpc & ~32'd3;
      // Delay-slot victims restart at the branch; subtraction wraps naturally.
      w_epc_trap = bus.bd_in ? (w_vpc_al - 32'd4) : w_vpc_al;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_ip       <= '0;
         r_exc_code <= '0;
         r_epc      <= '0;
      end else begin
         r_ip <= bus.hw_int;
         if (w_int_req) begin
            r_exl      <= 1'b1;
            r_bd       <= bus.bd_in;
            r_exc_code <= w_int_pend ? EXC_INT : bus.exc_code_in;
            r_epc      <= w_epc_trap;
         end else begin
            if (bus.exl_clr)
               r_exl <= 1'b0;
            if (bus.en) begin
               case (bus.cp0_addr)
                  REG_SR: begin
                     r_im  <= bus.cp0_in[15:10];
                     r_ie  <= bus.cp0_in[0];
                     r_exl <= bus.exl_clr ? 1'b0 : bus.cp0_in[1];
                  end
                  REG_EPC: r_epc <= bus.cp0_in;
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      case (bus.cp0_addr)
         REG_SR:    bus.cp0_out = {16'd0, r_im, 8'd0, r_exl, r_ie};
         REG_CAUSE: bus.cp0_out = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
         REG_EPC:   bus.cp0_out = r_epc;
         REG_PRID:  bus.cp0_out = PRID_VALUE;
         default:   bus.cp0_out = 32'd0;
      endcase
   end

   assign bus.epc_out = r_epc;
   assign bus.int_req = w_int_req;
   assign bus.trap_pc = TRAP_ADDR;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: word-level reference model plus directed scenarios.
module tb_cp0;

   localparam logic [31:0] PRID = 32'h2025_0007;
   localparam logic [31:0] TRAP = 32'h0000_4180;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   bit   started = 1'b0;

   cp0_if bus ();

   cp0 #(.PRID_VALUE(PRID), .TRAP_ADDR(TRAP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: whole architectural words, updated from the register rules.
   logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0;

   function automatic logic m_int_pend();
      return ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_req();
      return m_int_pend() || ((bus.exc_code_in != 5'd0) && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [31:0] sr, cause, epc;
      sr = m_sr; cause = m_cause; epc = m_epc;
      if (reset) begin
         sr = '0; cause = '0; epc = '0;
      end else begin
         cause[15:10] = bus.hw_int;
         if (m_req()) begin
            sr = sr | 32'h2;
            cause[31] = bus.bd_in;
            cause[6:2] = m_int_pend() ? 5'd0 : bus.exc_code_in;
            epc = (bus.vpc & 32'hFFFF_FFFC) - (bus.bd_in ? 32'd4 : 32'd0);
         end else begin
            if (bus.en && bus.cp0_addr == 5'd12) sr = bus.cp0_in & 32'h0000_FC03;
            if (bus.en && bus.cp0_addr == 5'd14) epc = bus.cp0_in;
            if (bus.exl_clr) sr = sr & ~32'h2;
         end
      end
      m_sr <= sr; m_cause <= cause; m_epc <= epc;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("model int_req", {31'd0, bus.int_req}, {31'd0, m_req()});
         chk("model cp0_out", bus.cp0_out, m_read(bus.cp0_addr));
         chk("model epc_out", bus.epc_out, m_epc);
         chk("trap_pc", bus.trap_pc, TRAP);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.en = 0; bus.cp0_addr = 0; bus.cp0_in = 0; bus.vpc = 0; bus.bd_in = 0;
      bus.exc_code_in = 0; bus.hw_int = 0; bus.exl_clr = 0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.en = 1; bus.cp0_addr = a; bus.cp0_in = d;
      tick();
      bus.en = 0;
   endtask

   task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
      bus.cp0_addr = a;
      #1;
      chk(name, bus.cp0_out, exp);
   endtask

   task automatic req(input string name, input logic exp);
      #1;
      chk(name, {31'd0, bus.int_req}, {31'd0, exp});
   endtask

   initial begin
      idle();
      reset = 1;
      tick(); tick();
      started = 1'b1;
      reset = 0;
      rd("reset sr", 5'd12, 32'h0);
      rd("reset cause", 5'd13, 32'h0);
      rd("reset epc", 5'd14, 32'h0);
      req("reset int_req", 1'b0);

      // Unmasked hw interrupt
      mtc0(5'd12, 32'h0000_FC01);
      rd("sr written", 5'd12, 32'h0000_FC01);
      bus.hw_int = 6'b000001; bus.vpc = 32'h0000_1234;
      req("hw irq int_req", 1'b1);
      tick();
      rd("irq cause", 5'd13, 32'h0000_0400);
      rd("irq sr exl", 5'd12, 32'h0000_FC03);
      chk("irq epc", bus.epc_out, 32'h0000_1234);
      req("exl masks irq", 1'b0);
      bus.hw_int = 0; bus.exl_clr = 1;
      tick();
      bus.exl_clr = 0;
      rd("eret sr", 5'd12, 32'h0000_FC01);

      // Overflow in a delay slot
      bus.exc_code_in = 5'd12; bus.vpc = 32'h0000_3010; bus.bd_in = 1;
      req("ov int_req", 1'b1);
      tick();
      bus.exc_code_in = 0; bus.bd_in = 0;
      chk("ov epc", bus.epc_out, 32'h0000_300C);
      rd("ov cause", 5'd13, 32'h8000_0030);
      rd("ov sr", 5'd12, 32'h0000_FC03);

      // Nested exception masked by EXL
      bus.exc_code_in = 5'd10; bus.vpc = 32'h0000_7000;
      req("nested masked", 1'b0);
      tick();
      bus.exc_code_in = 0;
      chk("nested epc kept", bus.epc_out, 32'h0000_300C);
      rd("nested cause kept", 5'd13, 32'h8000_0030);
      bus.exl_clr = 1;
      tick();
      bus.exl_clr = 0;
      rd("eret2 sr", 5'd12, 32'h0000_FC01);

      // Interrupt beats exception and mtc0 in the same cycle
      bus.hw_int = 6'b000100; bus.exc_code_in = 5'd4; bus.vpc = 32'h0000_4000;
      bus.en = 1; bus.cp0_addr = 5'd14; bus.cp0_in = 32'h0000_5000;
      req("prio int_req", 1'b1);
      tick();
      bus.en = 0; bus.exc_code_in = 0;
      chk("prio epc", bus.epc_out, 32'h0000_4000);
      rd("prio cause", 5'd13, 32'h0000_1000);
      bus.hw_int = 0;

      // eret and mtc0 SR together: EXL cleared, IM/IE from data
      bus.exl_clr = 1;
      mtc0(5'd12, 32'h0000_FC03);
      bus.exl_clr = 0;
      rd("eret+mtc0 sr", 5'd12, 32'h0000_FC01);

      // Cause is read-only to mtc0
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd("cause ro", 5'd13, 32'h0);
      rd("prid", 5'd15, PRID);
      rd("unimpl reg", 5'd3, 32'h0);
      mtc0(5'd14, 32'hDEAD_BEE0);
      chk("mtc0 epc", bus.epc_out, 32'hDEAD_BEE0);

      // IE=0 blocks all interrupts, IP still tracks lines
      mtc0(5'd12, 32'h0000_FC00);
      bus.hw_int = 6'b111111;
      req("ie0 int_req", 1'b0);
      tick();
      rd("ie0 ip", 5'd13, 32'h0000_FC00);
      bus.hw_int = 0;
      mtc0(5'd12, 32'h0000_FC01);

      // Unaligned victim PC, then wrap on vpc=0 in delay slot
      bus.exc_code_in = 5'd5; bus.vpc = 32'h0000_2003;
      tick();
      bus.exc_code_in = 0;
      chk("aligned epc", bus.epc_out, 32'h0000_2000);
      rd("ades cause", 5'd13, 32'h0000_0014);
      bus.exl_clr = 1; tick(); bus.exl_clr = 0;
      bus.exc_code_in = 5'd8; bus.vpc = 32'h0; bus.bd_in = 1;
      tick();
      bus.exc_code_in = 0; bus.bd_in = 0;
      chk("wrap epc", bus.epc_out, 32'hFFFF_FFFC);

      // Reset wins over a pending trap and mtc0
      bus.exl_clr = 1; tick(); bus.exl_clr = 0;
      bus.exc_code_in = 5'd8; bus.vpc = 32'h0000_9000;
      bus.en = 1; bus.cp0_addr = 5'd14; bus.cp0_in = 32'h1111_1110;
      reset = 1;
      tick();
      reset = 0; idle();
      chk("reset prio epc", bus.epc_out, 32'h0);
      rd("reset prio sr", 5'd12, 32'h0);
      rd("reset prio cause", 5'd13, 32'h0);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
